// File: rtl/mips_pkg.sv
// Shared constants and the IF/ID bundle type for the MIPS fetch stage.
package mips_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instruction;
    logic [PC_W-1:0] pc_plus1;
  } ifid_t;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: stall hold, jump, branch, or sequential word increment.
module mips_next_pc #(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] if_pc_plus1,
  input  logic            stall,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] offset_ext;

  assign offset_ext = {{(PC_W-16){branch_offset[15]}}, branch_offset};

  // Jump beats branch; both are relative to the IF/ID PC+1, not the current PC.
  always_comb begin
    next_pc = pc;
    if (!stall) begin
      if (jump) begin
        next_pc = {if_pc_plus1[PC_W-1:26], jump_target};
      end else if (branch_taken) begin
        next_pc = if_pc_plus1 + offset_ext;
      end else begin
        next_pc = pc + PC_W'(1);
      end
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: PC register, IF/ID register and accepted-instruction counter.
// Define MIPS_DELAY_SLOT_EN to keep the instruction fetched alongside a taken redirect.
module mips_fetch_unit #(
  parameter int unsigned     PC_W     = mips_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] program_counter,
  input  logic [31:0]     instruction,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  output logic            if_valid,
  output logic [31:0]     if_instruction,
  output logic [PC_W-1:0] if_pc_plus1,
  output logic [15:0]     fetch_count
);

  import mips_pkg::*;

  logic [PC_W-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  logic [15:0]     count_q, count_d;
  logic            squash;

  mips_next_pc #(
    .PC_W(PC_W)
  ) u_next_pc (
    .pc           (pc_q),
    .if_pc_plus1  (ifid_q.pc_plus1),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .next_pc      (pc_d)
  );

`ifdef MIPS_DELAY_SLOT_EN
  assign squash = flush;
`else
  // Without delay slots the word fetched beside a redirect is on the wrong path.
  assign squash = flush | jump | branch_taken;
`endif

  always_comb begin
    ifid_d  = ifid_q;
    count_d = count_q;
    if (!stall) begin
      ifid_d.valid       = 1'b1;
      ifid_d.instruction = instruction;
      ifid_d.pc_plus1    = pc_q + PC_W'(1);
      if (squash) begin
        ifid_d.valid       = 1'b0;
        ifid_d.instruction = NOP_INSTR;
      end
      if (ifid_d.valid) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, instruction: NOP_INSTR, pc_plus1: '0};
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      count_q <= count_d;
    end
  end

  assign program_counter = pc_q;
  assign if_valid        = ifid_q.valid;
  assign if_instruction  = ifid_q.instruction;
  assign if_pc_plus1     = ifid_q.pc_plus1;
  assign fetch_count     = count_q;

endmodule
